// File: rtl/cla_adder.sv
// 8-bit two-level carry-lookahead adder: per-bit p/g cells, two 4-bit lookahead
// groups joined by a group-level lookahead, plus a registered copy of the sum.

module pg_cell (
  input  logic a,
  input  logic b,
  output logic p,
  output logic g
);
  assign p = a ^ b;
  assign g = a & b;
endmodule

// Flat sum-of-products lookahead for one nibble; c[i] is the carry into bit i.
module cla4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] c,
  output logic       pg,
  output logic       gg
);
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [8:0] S,
  output logic [8:0] S_q,
  output logic [1:0] P_g,
  output logic [1:0] G_g
);
  logic [7:0] p;
  logic [7:0] g;
  logic [7:0] c;

  for (genvar i = 0; i < 8; i++) begin : g_pg
    pg_cell u_pg (
      .a (A[i]),
      .b (B[i]),
      .p (p[i]),
      .g (g[i])
    );
  end

  cla4 u_cla_lo (
    .p   (p[3:0]),
    .g   (g[3:0]),
    .cin (1'b0),
    .c   (c[3:0]),
    .pg  (P_g[0]),
    .gg  (G_g[0])
  );

  // Carry-in is zero, so the high group's carry-in is just the low group's generate.
  cla4 u_cla_hi (
    .p   (p[7:4]),
    .g   (g[7:4]),
    .cin (G_g[0]),
    .c   (c[7:4]),
    .pg  (P_g[1]),
    .gg  (G_g[1])
  );

  assign S[7:0] = p ^ c;
  assign S[8]   = G_g[1] | (P_g[1] & G_g[0]);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) S_q <= '0;
    else        S_q <= S;
  end
endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: directed vectors, latency, async reset,
// exhaustive and random sweeps against an arithmetic reference model.

module tb_cla_adder;
  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [8:0] S;
  logic [8:0] S_q;
  logic [1:0] P_g;
  logic [1:0] G_g;

  int errors = 0;
  int checks = 0;

  cla_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .S     (S),
    .S_q   (S_q),
    .P_g   (P_g),
    .G_g   (G_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: group propagate means the nibbles XOR to all ones; group
  // generate means the nibble sum carries out on its own.
  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
    return 9'(a) + 9'(b);
  endfunction

  function automatic logic [1:0] ref_pg(input logic [7:0] a, input logic [7:0] b);
    logic [1:0] r;
    r[0] = ((a[3:0] ^ b[3:0]) == 4'hF);
    r[1] = ((a[7:4] ^ b[7:4]) == 4'hF);
    return r;
  endfunction

  function automatic logic [1:0] ref_gg(input logic [7:0] a, input logic [7:0] b);
    logic [1:0] r;
    r[0] = (int'(a[3:0]) + int'(b[3:0])) > 15;
    r[1] = (int'(a[7:4]) + int'(b[7:4])) > 15;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    A = 8'd37;
    B = 8'd90;
    #1;
    checks++;
    if (S_q !== 9'h000) begin
      errors++;
      $display("FAIL reset_sq: got %h expected %h", S_q, 9'h000);
    end
    checks++;
    if (S !== 9'd127) begin
      errors++;
      $display("FAIL reset_s_follows: got %0d expected %0d", S, 127);
    end
    @(posedge clk); #1;
    checks++;
    if (S_q !== 9'h000) begin
      errors++;
      $display("FAIL reset_sq_hold: got %h expected %h", S_q, 9'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (S_q !== 9'd127) begin
      errors++;
      $display("FAIL reset_first_load: got %0d expected %0d", S_q, 127);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [12] = '{8'd0, 8'd1, 8'd255, 8'd10, 8'd127, 8'd240,
                            8'd5, 8'd170, 8'd0, 8'd255, 8'h0F, 8'hF0};
    logic [7:0] vb [12] = '{8'd0, 8'd1, 8'd1, 8'd5, 8'd1, 8'd15,
                            8'd3, 8'd85, 8'd85, 8'd255, 8'h01, 8'h10};
    int         vs [12] = '{0, 2, 256, 15, 128, 255, 8, 255, 85, 510, 16, 256};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      A = va[i];
      B = vb[i];
      #1;
      checks++;
      if (S !== 9'(vs[i])) begin
        errors++;
        $display("FAIL vec%0d_sum: A=%0d B=%0d got %0d expected %0d", i, va[i], vb[i], S, vs[i]);
      end
      checks++;
      if (S[8] !== (vs[i] > 255)) begin
        errors++;
        $display("FAIL vec%0d_cout: got %b expected %b", i, S[8], vs[i] > 255);
      end
    end
  endtask

  task automatic test_group();
    @(negedge clk);
    A = 8'd170; B = 8'd85; #1;
    checks++;
    if (P_g !== 2'b11 || G_g !== 2'b00) begin
      errors++;
      $display("FAIL group_aa55: P_g=%b G_g=%b expected P_g=11 G_g=00", P_g, G_g);
    end
    A = 8'h0F; B = 8'h01; #1;
    checks++;
    if (G_g[0] !== 1'b1 || dut.c[4] !== 1'b1 || S !== 9'd16) begin
      errors++;
      $display("FAIL group_low_gen: G_g0=%b c4=%b S=%0d expected 1 1 16", G_g[0], dut.c[4], S);
    end
    A = 8'hF0; B = 8'h10; #1;
    checks++;
    if (G_g[1] !== 1'b1 || S !== 9'd256) begin
      errors++;
      $display("FAIL group_high_gen: G_g1=%b S=%0d expected 1 256", G_g[1], S);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    A = 8'd0; B = 8'd0;
    @(posedge clk);
    @(negedge clk);
    A = 8'd200; B = 8'd100; #1;
    checks++;
    if (S !== 9'd300) begin
      errors++;
      $display("FAIL latency_s: got %0d expected %0d", S, 300);
    end
    checks++;
    if (S_q !== 9'd0) begin
      errors++;
      $display("FAIL latency_early: got %0d expected %0d before edge", S_q, 0);
    end
    @(posedge clk); #1;
    checks++;
    if (S_q !== 9'd300) begin
      errors++;
      $display("FAIL latency_sq: got %0d expected %0d", S_q, 300);
    end
  endtask

  task automatic test_async_reset();
    // Entered with S_q = 300 from the latency test, just after a rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (S_q !== 9'd0) begin
      errors++;
      $display("FAIL async_clear: got %0d expected %0d", S_q, 0);
    end
    checks++;
    if (S !== 9'd300) begin
      errors++;
      $display("FAIL async_s_live: got %0d expected %0d", S, 300);
    end
    @(negedge clk);
    A = 8'd1; B = 8'd2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (S_q !== 9'd0) begin
      errors++;
      $display("FAIL async_no_residual: got %0d expected %0d", S_q, 0);
    end
    @(posedge clk); #1;
    checks++;
    if (S_q !== 9'd3) begin
      errors++;
      $display("FAIL async_reload: got %0d expected %0d", S_q, 3);
    end
  endtask

  task automatic test_exhaustive();
    int ex_err = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        @(negedge clk);
        A = 8'(a);
        B = 8'(b);
        #1;
        checks++;
        if (S !== ref_sum(A, B) || P_g !== ref_pg(A, B) || G_g !== ref_gg(A, B)) begin
          errors++;
          if (ex_err++ < 10)
            $display("FAIL exh_comb: A=%0d B=%0d S=%0d P_g=%b G_g=%b expected %0d %b %b",
                     A, B, S, P_g, G_g, ref_sum(A, B), ref_pg(A, B), ref_gg(A, B));
        end
        @(posedge clk); #1;
        checks++;
        if (S_q !== 9'(a + b)) begin
          errors++;
          if (ex_err++ < 10)
            $display("FAIL exh_reg: A=%0d B=%0d S_q=%0d expected %0d", a, b, S_q, a + b);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_q [$];
    logic [7:0] ra;
    logic [7:0] rb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      A = ra;
      B = rb;
      exp_q.push_back(int'(ra) + int'(rb));
      #1;
      checks++;
      if (S !== ref_sum(ra, rb)) begin
        errors++;
        $display("FAIL rand_comb: A=%0d B=%0d got %0d expected %0d", ra, rb, S, ref_sum(ra, rb));
      end
      @(posedge clk); #1;
      checks++;
      if (S_q !== 9'(exp_q[0])) begin
        errors++;
        $display("FAIL rand_reg: got %0d expected %0d", S_q, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_group();
    test_latency();
    test_async_reset();
    test_exhaustive();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
